core2axi_mo: RTL and testbench
==============================

Name: core2axi_mo

Overview:
- Bridges the core data port (req/gnt/rvalid protocol) to AXI4 single-beat transactions, supporting up to MAX_OUTSTANDING in-flight requests.
- Successor to the single-outstanding core-to-AXI converter. Adds a configurable outstanding depth, in-order completion across mixed reads and writes, error reporting, and registered AXI request channels.
- Sits between the core LSU and the system AXI crossbar.

Parameters:
- ADDR_WIDTH, 32, address width of core and AXI.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- ID_WIDTH, 4, AXI ID width.
- AXI_ID, 0, constant ID driven on AW/AR.
- MAX_OUTSTANDING, 4, max granted-but-uncompleted requests; >=1, power of 2.
- AXI_PROT, 3'b000, constant AxPROT.

Ports:
- clk_i in 1 clock
- rst_ni in 1 asynchronous active-low reset
- data_req_i in 1 core request
- data_gnt_o out 1 request accepted this cycle
- data_addr_i in ADDR_WIDTH byte address
- data_we_i in 1 1=write
- data_be_i in DATA_WIDTH/8 byte enables
- data_wdata_i in DATA_WIDTH write data
- data_rvalid_o out 1 response valid (one per grant, in grant order)
- data_rdata_o out DATA_WIDTH read data; 0 for writes
- data_err_o out 1 response error, qualified by rvalid
- aw_valid_o/aw_ready_i, aw_addr_o ADDR_WIDTH, aw_id_o ID_WIDTH, aw_prot_o 3: AXI AW channel
- w_valid_o/w_ready_i, w_data_o DATA_WIDTH, w_strb_o DATA_WIDTH/8, w_last_o 1: AXI W channel
- b_valid_i/b_ready_o, b_resp_i 2: AXI B channel
- ar_valid_o/ar_ready_i, ar_addr_o, ar_id_o, ar_prot_o: AXI AR channel
- r_valid_i/r_ready_o, r_data_i DATA_WIDTH, r_resp_i 2, r_last_i 1: AXI R channel

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous, active-low, on rst_ni.
- Reset values: all *_valid_o=0, data_gnt_o=0, data_rvalid_o=0, data_err_o=0, data_rdata_o=0, outstanding count=0, order FIFO empty.
- Constant AXI fields: AxLEN=0, AxSIZE=log2(DATA_WIDTH/8), AxBURST=INCR, AxCACHE=0, AxLOCK=0, w_last_o=1.

Grant (combinational):
- data_gnt_o = data_req_i && cnt<MAX_OUTSTANDING && channel_free.
- channel_free for writes: !aw_valid_q && !w_valid_q.
- channel_free for reads: !ar_valid_q.
- No other combinational path from data_req_i to AXI outputs.

On grant (cycle N):
- Address, data and strobe are registered into the channel regs.
- The matching valid(s) assert at N+1: aw_valid and w_valid together for a write, ar_valid for a read.
- Each valid deasserts independently on its own handshake. AW and W may complete in either order.
- Register contents are held stable while valid is high.
- Push op type (0=read, 1=write) into an order FIFO of depth MAX_OUTSTANDING.
- cnt increments.

Response acceptance:
- r_ready_o = order FIFO non-empty && head==read.
- b_ready_o = order FIFO non-empty && head==write.
- This enforces core-order completion; reads and writes are never reordered relative to each other.

On R or B handshake (cycle M):
- data_rvalid_o=1 at M+1 for exactly one cycle.
- data_rdata_o = r_data_i for a read, 0 for a write.
- data_err_o = resp[1] (SLVERR/DECERR→1; OKAY/EXOKAY→0).
- Pop the FIFO and decrement cnt at M.
- Latency minimum: read grant N → rvalid N+3 with ar_ready and r_valid both high immediately.

Simultaneous events:
- Grant and response in the same cycle: cnt stays unchanged, FIFO pushes and pops together (legal when full: pop frees the slot, but the gnt check still uses the pre-pop cnt, so no grant at full).
- At cnt==MAX_OUTSTANDING: gnt=0 until a response completes.
- A response arriving while the FIFO is empty is not accepted (ready=0).

Reset mid-operation:
- All state clears immediately and in-flight transactions are dropped.
- The system must reset the AXI slave concurrently.

Sizing:
- Counter width is clog2(MAX_OUTSTANDING+1).
- FIFO pointers wrap modulo MAX_OUTSTANDING.

Test Plan:
1. Single read 0x1000, AR/R ready immediate, r_data=0xDEADBEEF OKAY → gnt cycle 0, ar_valid cycle 1 with ar_addr 0x1000, rvalid cycle 3, rdata 0xDEADBEEF, err 0.
2. Write 0x2004, be=0b0011, wdata=0x0000CAFE; W ready 2 cycles before AW → aw/w_valid assert together, each drops on its own handshake, w_strb=0x3, one rvalid with rdata 0, err 0.
3. MAX_OUTSTANDING=4, 6 back-to-back reads, slave withholds R → exactly 4 grants then gnt=0. Releasing one R → 5th grant the cycle after the completion; responses come in issue order.
4. Interleave read A, write B, read C; slave presents B response before R(A) → b_ready stays 0 until R(A) completes; core sees A, B, C in order.
5. Read returns r_resp=DECERR, then write returns b_resp=SLVERR → both responses have data_err_o=1; a following OKAY has err=0.
6. Assert rst_ni low while 3 requests are outstanding and ar_valid is high → all valids, rvalid and cnt are 0 immediately. After release, a new read completes normally.

Source files
------------

// File: rtl/core2axi_mo_if.sv
// AXI4 channel bundle used by core2axi_mo.
// Purpose: groups the AW, W, B, AR and R channels of a single-beat AXI4 link.
// Modports:
//   master - bridge side: drives AW/W/AR payload and valids plus B/R ready,
//            and samples AW/W/AR ready and the B/R responses.
//   slave  - memory side: the mirror image of master.
interface core2axi_mo_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_WIDTH   = 4
);
    // AW channel
    logic                    aw_valid;
    logic                    aw_ready;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [ID_WIDTH-1:0]     aw_id;
    logic [2:0]              aw_prot;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic [3:0]              aw_cache;
    logic                    aw_lock;
    // W channel
    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    // B channel
    logic                    b_valid;
    logic                    b_ready;
    logic [1:0]              b_resp;
    // AR channel
    logic                    ar_valid;
    logic                    ar_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [2:0]              ar_prot;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic [3:0]              ar_cache;
    logic                    ar_lock;
    // R channel
    logic                    r_valid;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;

    modport master (
        output aw_valid, aw_addr, aw_id, aw_prot, aw_len, aw_size, aw_burst, aw_cache, aw_lock,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_resp,
        output b_ready,
        output ar_valid, ar_addr, ar_id, ar_prot, ar_len, ar_size, ar_burst, ar_cache, ar_lock,
        input  ar_ready,
        input  r_valid, r_data, r_resp, r_last,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_id, aw_prot, aw_len, aw_size, aw_burst, aw_cache, aw_lock,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_resp,
        input  b_ready,
        input  ar_valid, ar_addr, ar_id, ar_prot, ar_len, ar_size, ar_burst, ar_cache, ar_lock,
        output ar_ready,
        output r_valid, r_data, r_resp, r_last,
        input  r_ready
    );
endinterface

// File: rtl/core2axi_mo.sv
// Core data port (req/gnt/rvalid) to AXI4 single-beat bridge with up to
// MAX_OUTSTANDING in-flight requests and in-order completion.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   data_req_i .. _wdata_i  core request side; data_gnt_o accepts it (combinational)
//   data_rvalid_o/_rdata_o/_err_o  one response per grant, in grant order
//   axi                  AXI4 master port (AW/W/B/AR/R), request channels registered
// DATA_WIDTH must be 32 or 64; MAX_OUTSTANDING must be a power of two >= 1.
module core2axi_mo #(
    parameter int unsigned         ADDR_WIDTH      = 32,
    parameter int unsigned         DATA_WIDTH      = 32,
    parameter int unsigned         ID_WIDTH        = 4,
    parameter logic [ID_WIDTH-1:0] AXI_ID          = '0,
    parameter int unsigned         MAX_OUTSTANDING = 4,
    parameter logic [2:0]          AXI_PROT        = 3'b000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    data_req_i,
    output logic                    data_gnt_o,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    data_err_o,
    core2axi_mo_if.master           axi
);
    localparam int unsigned    CntW   = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned    PtrW   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_OUTSTANDING);
    localparam logic [2:0]     AxSize = 3'($clog2(DATA_WIDTH / 8));

    logic                    aw_valid_q, aw_valid_d, w_valid_q, w_valid_d, ar_valid_q, ar_valid_d;
    logic [ADDR_WIDTH-1:0]   aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic [DATA_WIDTH/8-1:0] w_strb_q, w_strb_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    // Order FIFO: one bit per slot, 1 = write.
    logic [MAX_OUTSTANDING-1:0] op_q, op_d;
    logic                    rvalid_q, rvalid_d, err_q, err_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic fifo_empty, head_is_wr, ch_free, gnt, r_hs, b_hs, pop;
    logic unused_bits;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        fifo_empty = (cnt_q == '0);
        head_is_wr = op_q[rd_ptr_q];
        r_hs       = axi.r_valid && !fifo_empty && !head_is_wr;
        b_hs       = axi.b_valid && !fifo_empty && head_is_wr;
        pop        = r_hs || b_hs;
        ch_free    = data_we_i ? (!aw_valid_q && !w_valid_q) : !ar_valid_q;
        // Uses the pre-pop count: no grant at full even if a response pops this cycle.
        gnt        = data_req_i && (cnt_q < CntMax) && ch_free;
    end

    always_comb begin
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        ar_valid_d = ar_valid_q;
        aw_addr_d  = aw_addr_q;
        ar_addr_d  = ar_addr_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        op_d       = op_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;

        if (aw_valid_q && axi.aw_ready) aw_valid_d = 1'b0;
        if (w_valid_q && axi.w_ready)   w_valid_d  = 1'b0;
        if (ar_valid_q && axi.ar_ready) ar_valid_d = 1'b0;

        // A grant only happens while the target channel is idle, so payload
        // registers never change under an asserted valid.
        if (gnt) begin
            if (data_we_i) begin
                aw_valid_d = 1'b1;
                w_valid_d  = 1'b1;
                aw_addr_d  = data_addr_i;
                w_data_d   = data_wdata_i;
                w_strb_d   = data_be_i;
            end else begin
                ar_valid_d = 1'b1;
                ar_addr_d  = data_addr_i;
            end
            op_d[wr_ptr_q] = data_we_i;
            wr_ptr_d       = ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);

        unique case ({gnt, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        rvalid_d = pop;
        rdata_d  = r_hs ? axi.r_data : '0;
        err_d    = r_hs ? axi.r_resp[1] : (b_hs && axi.b_resp[1]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            ar_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            op_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            ar_valid_q <= ar_valid_d;
            aw_addr_q  <= aw_addr_d;
            ar_addr_q  <= ar_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            op_q       <= op_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign data_gnt_o    = gnt;
    assign data_rvalid_o = rvalid_q;
    assign data_rdata_o  = rdata_q;
    assign data_err_o    = err_q;

    assign axi.aw_valid = aw_valid_q;
    assign axi.aw_addr  = aw_addr_q;
    assign axi.aw_id    = AXI_ID;
    assign axi.aw_prot  = AXI_PROT;
    assign axi.aw_len   = 8'd0;
    assign axi.aw_size  = AxSize;
    assign axi.aw_burst = 2'b01;
    assign axi.aw_cache = 4'b0000;
    assign axi.aw_lock  = 1'b0;
    assign axi.w_valid  = w_valid_q;
    assign axi.w_data   = w_data_q;
    assign axi.w_strb   = w_strb_q;
    assign axi.w_last   = 1'b1;
    assign axi.b_ready  = !fifo_empty && head_is_wr;
    assign axi.ar_valid = ar_valid_q;
    assign axi.ar_addr  = ar_addr_q;
    assign axi.ar_id    = AXI_ID;
    assign axi.ar_prot  = AXI_PROT;
    assign axi.ar_len   = 8'd0;
    assign axi.ar_size  = AxSize;
    assign axi.ar_burst = 2'b01;
    assign axi.ar_cache = 4'b0000;
    assign axi.ar_lock  = 1'b0;
    assign axi.r_ready  = !fifo_empty && !head_is_wr;

    // Single-beat only: r_last and the low response bits carry no information here.
    assign unused_bits = ^{axi.r_last, axi.r_resp[0], axi.b_resp[0]};
endmodule

// File: tb/tb_core2axi_mo.sv
module tb_core2axi_mo;
    localparam int unsigned AW = 32, DW = 32, IW = 4, MO = 4;

    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    core2axi_mo_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) axi ();

    core2axi_mo #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .AXI_ID(4'd0),
        .MAX_OUTSTANDING(MO), .AXI_PROT(3'b000)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .data_req_i(req), .data_gnt_o(gnt),
        .data_addr_i(addr), .data_we_i(we), .data_be_i(be), .data_wdata_i(wdata),
        .data_rvalid_o(rvalid), .data_rdata_o(rdata), .data_err_o(err), .axi(axi)
    );

    // Slave knobs and slave-driven signals
    logic ar_rdy = 0, aw_rdy = 0, w_rdy = 0, r_en = 0, b_en = 0;
    logic s_rv = 0, s_bv = 0;
    logic [31:0] s_rd = '0;
    logic [1:0]  s_rr = '0, s_br = '0;
    assign axi.ar_ready = ar_rdy;
    assign axi.aw_ready = aw_rdy;
    assign axi.w_ready  = w_rdy;
    assign axi.r_valid  = s_rv;
    assign axi.r_data   = s_rd;
    assign axi.r_resp   = s_rr;
    assign axi.r_last   = 1'b1;
    assign axi.b_valid  = s_bv;
    assign axi.b_resp   = s_br;

    // Memory contents and response codes are a pure function of the address.
    function automatic logic [31:0] rdata_for(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
        return {a[15:0], ~a[15:0]};
    endfunction
    function automatic logic [1:0] resp_for(input logic [31:0] a);
        case (a[15:12])
            4'hE:    return 2'b11;
            4'hF:    return 2'b10;
            4'hC:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req_v, $time);
        end
    endtask

    // AXI slave: R answers accepted ARs in order, B answers completed AW+W pairs.
    logic [31:0] ar_q[$], aw_q[$];
    int w_cnt = 0;
    initial begin
        logic arh, awh, wh, rh, bh;
        logic [31:0] ara, awa;
        forever begin
            @(negedge clk);
            arh = axi.ar_valid && axi.ar_ready; ara = axi.ar_addr;
            awh = axi.aw_valid && axi.aw_ready; awa = axi.aw_addr;
            wh  = axi.w_valid && axi.w_ready;
            rh  = axi.r_valid && axi.r_ready;
            bh  = axi.b_valid && axi.b_ready;
            @(posedge clk); #2;
            if (!rst_n) begin
                ar_q.delete(); aw_q.delete(); w_cnt = 0;
            end else begin
                if (arh) ar_q.push_back(ara);
                if (awh) aw_q.push_back(awa);
                if (wh)  w_cnt++;
                if (rh)  void'(ar_q.pop_front());
                if (bh) begin void'(aw_q.pop_front()); w_cnt--; end
            end
            s_rv = r_en && (ar_q.size() > 0);
            s_rd = s_rv ? rdata_for(ar_q[0]) : 32'h0;
            s_rr = s_rv ? resp_for(ar_q[0]) : 2'b00;
            s_bv = b_en && (aw_q.size() > 0) && (w_cnt > 0);
            s_br = s_bv ? resp_for(aw_q[0]) : 2'b00;
        end
    end

    // Reference model: every grant owes exactly one response, in grant order.
    typedef struct packed { logic [31:0] d; logic e; } exp_t;
    exp_t exp_q[$];
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (rvalid) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL rsp_unexpected actual=rvalid required=none (t=%0t)", $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_rdata", rdata, e.d);
                        chk("rsp_err", err, e.e);
                    end
                end
                if (gnt) begin
                    chk("gnt_below_max", exp_q.size() < MO, 1);
                    e.d = we ? 32'h0 : rdata_for(addr);
                    e.e = resp_for(addr) >= 2'b10;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d, output int gc);
        req = 1'b1; we = w; addr = a; be = b; wdata = d; gc = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (gnt) begin gc = cyc; break; end
            @(posedge clk); #1;
        end
        chk("gnt_seen", gc >= 0, 1);
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] d, output logic e, output int rc);
        rc = -1; d = '0; e = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rvalid) begin rc = cyc; d = rdata; e = err; break; end
        end
        chk("rvalid_seen", rc >= 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin ok = 1; break; end
        end
        chk("drained", ok, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, rc, hs;
        logic [31:0] d;
        logic e;

        // Reset state and constant AXI fields
        repeat (2) @(negedge clk);
        chk("rst_rvalid", rvalid, 0);   chk("rst_rdata", rdata, 0);
        chk("rst_err", err, 0);         chk("rst_gnt", gnt, 0);
        chk("rst_aw_valid", axi.aw_valid, 0); chk("rst_w_valid", axi.w_valid, 0);
        chk("rst_ar_valid", axi.ar_valid, 0);
        chk("rst_r_ready", axi.r_ready, 0);   chk("rst_b_ready", axi.b_ready, 0);
        chk("aw_len", axi.aw_len, 0);   chk("ar_len", axi.ar_len, 0);
        chk("aw_size", axi.aw_size, 2); chk("ar_size", axi.ar_size, 2);
        chk("aw_burst", axi.aw_burst, 1); chk("ar_burst", axi.ar_burst, 1);
        chk("ar_cache", axi.ar_cache, 0); chk("aw_lock", axi.aw_lock, 0);
        chk("w_last", axi.w_last, 1);   chk("ar_prot", axi.ar_prot, 0);
        chk("ar_id", axi.ar_id, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: single read, minimum latency
        ar_rdy = 1; r_en = 1;
        issue(1'b0, 32'h1000, 4'hF, 32'h0, g);
        @(negedge clk);
        chk("t1_ar_valid", axi.ar_valid, 1);
        chk("t1_ar_addr", axi.ar_addr, 32'h1000);
        wait_rsp(d, e, rc);
        chk("t1_latency", rc - g, 3);
        chk("t1_rdata", d, 32'hDEAD_BEEF);
        chk("t1_err", e, 0);

        // 2: write, W accepted two cycles before AW
        aw_rdy = 0; w_rdy = 1; b_en = 1;
        issue(1'b1, 32'h2004, 4'b0011, 32'h0000_CAFE, g);
        @(negedge clk);
        chk("t2_aw_valid", axi.aw_valid, 1); chk("t2_w_valid", axi.w_valid, 1);
        chk("t2_w_strb", axi.w_strb, 4'h3);  chk("t2_w_data", axi.w_data, 32'h0000_CAFE);
        chk("t2_aw_addr", axi.aw_addr, 32'h2004);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_w_dropped", axi.w_valid, 0); chk("t2_aw_held", axi.aw_valid, 1);
        chk("t2_aw_addr_held", axi.aw_addr, 32'h2004);
        @(posedge clk); #1;
        aw_rdy = 1;
        @(negedge clk);
        chk("t2_aw_hs", axi.aw_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_aw_dropped", axi.aw_valid, 0);
        wait_rsp(d, e, rc);
        chk("t2_rdata", d, 0);
        chk("t2_err", e, 0);

        // 3: six reads against a stalled R channel
        ar_rdy = 1; r_en = 0;
        for (int i = 0; i < 4; i++) issue(1'b0, 32'h3000 + 32'(i * 16), 4'hF, 32'h0, g);
        req = 1; we = 0; addr = 32'h3040;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t3_full_no_gnt", gnt, 0);
            @(posedge clk); #1;
        end
        r_en = 1;
        @(negedge clk);
        hs = cyc;
        chk("t3_r_hs", axi.r_valid && axi.r_ready, 1);
        chk("t3_no_gnt_at_hs", gnt, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t3_gnt_after_hs", gnt, 1);
        chk("t3_gnt_cycle", cyc - hs, 1);
        @(posedge clk); #1;
        req = 0;
        issue(1'b0, 32'h3050, 4'hF, 32'h0, g);
        wait_idle();

        // 4: read A, write B, read C; B response presented before R(A)
        ar_rdy = 1; aw_rdy = 1; w_rdy = 1; r_en = 0; b_en = 1;
        issue(1'b0, 32'h4000, 4'hF, 32'h0, g);
        issue(1'b1, 32'h4100, 4'hF, 32'h1111_2222, g);
        issue(1'b0, 32'h4200, 4'hF, 32'h0, g);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_b_presented", axi.b_valid, 1);
            chk("t4_b_ready_low", axi.b_ready, 0);
            @(posedge clk); #1;
        end
        r_en = 1;
        wait_rsp(d, e, rc); chk("t4_a_rdata", d, 32'h4000_BFFF);
        wait_rsp(d, e, rc); chk("t4_b_rdata", d, 32'h0);
        wait_rsp(d, e, rc); chk("t4_c_rdata", d, 32'h4200_BDFF);
        wait_idle();

        // 5: error responses
        issue(1'b0, 32'hE000, 4'hF, 32'h0, g);
        wait_rsp(d, e, rc); chk("t5_decerr", e, 1); chk("t5_decerr_data", d, 32'hE000_1FFF);
        issue(1'b1, 32'hF000, 4'hF, 32'hAAAA_5555, g);
        wait_rsp(d, e, rc); chk("t5_slverr", e, 1); chk("t5_slverr_data", d, 0);
        issue(1'b0, 32'h5000, 4'hF, 32'h0, g);
        wait_rsp(d, e, rc); chk("t5_okay", e, 0); chk("t5_okay_data", d, 32'h5000_AFFF);
        issue(1'b0, 32'hC000, 4'hF, 32'h0, g);
        wait_rsp(d, e, rc); chk("t5_exokay", e, 0); chk("t5_exokay_data", d, 32'hC000_3FFF);

        // 6: reset with three requests outstanding and AR stuck
        ar_rdy = 0; aw_rdy = 1; w_rdy = 1; b_en = 0; r_en = 1;
        issue(1'b0, 32'h6000, 4'hF, 32'h0, g);
        issue(1'b1, 32'h6100, 4'hF, 32'h6161_6161, g);
        issue(1'b1, 32'h6200, 4'hF, 32'h6262_6262, g);
        @(negedge clk);
        chk("t6_ar_stuck", axi.ar_valid, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("t6_ar_valid", axi.ar_valid, 0); chk("t6_aw_valid", axi.aw_valid, 0);
        chk("t6_w_valid", axi.w_valid, 0);   chk("t6_rvalid", rvalid, 0);
        chk("t6_b_ready", axi.b_ready, 0);   chk("t6_r_ready", axi.r_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        ar_rdy = 1;
        issue(1'b0, 32'h7000, 4'hF, 32'h0, g);
        wait_rsp(d, e, rc);
        chk("t6_after_latency", rc - g, 3);
        chk("t6_after_rdata", d, 32'h7000_8FFF);
        chk("t6_after_err", e, 0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
